// File: rtl/spi_fp_pkg.sv
// spi_fp_pkg: shared defaults and types for the SPI fingerprint receiver.
//   DEF_BITS_PER_WORD   : default SPI word width
//   DEF_WORDS_PER_FRAME : default words per fingerprint frame
//   rx_state_t          : receiver FSM states
//   fp_word_t           : FIFO entry layout (last flag + data) at default width
package spi_fp_pkg;

    localparam int unsigned DEF_BITS_PER_WORD   = 8;
    localparam int unsigned DEF_WORDS_PER_FRAME = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic                         last;
        logic [DEF_BITS_PER_WORD-1:0] data;
    } fp_word_t;

endpackage

// File: rtl/spi_fp_sync_fifo.sv
// spi_fp_sync_fifo: first-word-fall-through synchronous FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write request; push_ok_o reports whether it was accepted
//   push_data_i   : write data
//   pop_i         : read request (ignored when empty)
//   rd_data_o     : head entry, forced to zero while empty
//   full_o/empty_o: occupancy flags
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module spi_fp_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ok_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok    = pop_i & ~empty_o;
    assign push_ok_o = push_i & (~full_o | pop_ok);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/spi_fingerprint_rx.sv
// spi_fingerprint_rx: SPI target receiver for the fingerprint stream.
// Oversamples sclk/cs/mosi in the clk domain, assembles words on sclk falling
// edges, tags every WORDS_PER_FRAME-th word as last, and buffers them in a
// FWFT FIFO behind a valid/ready stream.
//   clk, reset (async, active low)
//   sclk, cs (active low), mosi       : SPI lines from the transmitter
//   out_data, out_last, out_valid,
//   out_ready                         : output word stream
//   frame_done                        : pulse when a frame's last word is written
//   overflow, frame_error             : sticky flags, cleared by clear_errors
// Build option: define SPI_RX_MSB_FIRST_EN for MSB-first word assembly
// (default is LSB first).
module spi_fingerprint_rx
    import spi_fp_pkg::*;
#(
    parameter int unsigned BITS_PER_WORD   = DEF_BITS_PER_WORD,
    parameter int unsigned WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
    parameter int unsigned FIFO_DEPTH      = 32,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs,
    input  logic                     mosi,
    output logic [BITS_PER_WORD-1:0] out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     overflow,
    output logic                     frame_error,
    input  logic                     clear_errors
);

    localparam int unsigned CNT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int unsigned IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

    typedef struct packed {
        logic                     last;
        logic [BITS_PER_WORD-1:0] data;
    } word_t;

    // ---------------- synchronizers and edge detect ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic                   armed_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_dly_q & ~sclk_s;
    assign cs_fall   = cs_dly_q & ~cs_s;
    assign cs_rise   = ~cs_dly_q & cs_s;

    // The synchronizer resets to cs=1, so a cs already low at reset release
    // would look like a falling edge. armed_q only sets once the chain has
    // flushed and shows a genuine cs high, so such a phantom edge is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            if (settle_q[SYNC_STAGES] && cs_s) armed_q <= 1'b1;
        end
    end

    // ---------------- FSM ----------------
    rx_state_t state_q, state_d;
    logic      start_frame, take_bit, end_frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall && armed_q) state_d = RECV;
            RECV:    if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A cs rise masks an sclk edge detected in the same cycle.
    always_comb begin
        start_frame = 1'b0;
        take_bit    = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            IDLE: start_frame = cs_fall & armed_q;
            RECV: begin
                end_frame = cs_rise;
                take_bit  = sclk_fall & ~cs_rise;
            end
            default: ;
        endcase
    end

    // ---------------- word assembly ----------------
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d, bit_pos;
    logic [IDX_W-1:0]         word_idx_q, word_idx_d;
    logic                     push_q, push_d;
    word_t                    push_word_q, push_word_d;
    logic                     ferr_set, ovf_set;
    logic                     overflow_q, frame_error_q;

`ifdef SPI_RX_MSB_FIRST_EN
    assign bit_pos = LAST_BIT - bit_cnt_q;
`else
    assign bit_pos = bit_cnt_q;
`endif

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_idx_d  = word_idx_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        ferr_set    = 1'b0;
        if (start_frame) begin
            bit_cnt_d  = '0;
            word_idx_d = '0;
        end
        if (end_frame) begin
            ferr_set   = (bit_cnt_q != '0) || (word_idx_q != '0);
            bit_cnt_d  = '0;
            word_idx_d = '0;
        end
        if (take_bit) begin
            shift_d[bit_pos] = mosi_s;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d        = '0;
                push_d           = 1'b1;
                push_word_d.data = shift_d;
                push_word_d.last = (word_idx_q == LAST_IDX);
                word_idx_d       = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            push_q        <= 1'b0;
            push_word_q   <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_idx_q    <= word_idx_d;
            push_q        <= push_d;
            push_word_q   <= push_word_d;
            overflow_q    <= ovf_set | (overflow_q & ~clear_errors);
            frame_error_q <= ferr_set | (frame_error_q & ~clear_errors);
        end
    end

    // ---------------- output FIFO ----------------
    logic [BITS_PER_WORD:0] fifo_rd;
    word_t                  rd_word;
    logic                   push_ok, fifo_full, fifo_empty;

    spi_fp_sync_fifo #(
        .WIDTH (BITS_PER_WORD + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push_q),
        .push_data_i (push_word_q),
        .push_ok_o   (push_ok),
        .pop_i       (out_ready),
        .rd_data_o   (fifo_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rd_word     = fifo_rd;
    assign ovf_set     = push_q & fifo_full & ~push_ok;
    assign out_data    = rd_word.data;
    assign out_last    = rd_word.last;
    assign out_valid   = ~fifo_empty;
    assign frame_done  = push_q & push_word_q.last & push_ok;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_fingerprint_rx.sv
// tb_spi_fingerprint_rx: drives SPI sessions into spi_fingerprint_rx and
// checks the output stream against a word-level model of the receiver.
module tb_spi_fingerprint_rx;

    localparam int BPW   = 8;
    localparam int WPF   = 16;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       out_ready = 1'b1;
    logic       clear_errors = 1'b0;
    logic [7:0] out_data;
    logic       out_last, out_valid, frame_done, overflow, frame_error;

    always #5 clk = ~clk;

    spi_fingerprint_rx #(
        .BITS_PER_WORD   (BPW),
        .WORDS_PER_FRAME (WPF),
        .FIFO_DEPTH      (DEPTH),
        .SYNC_STAGES     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs           (cs),
        .mosi         (mosi),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .frame_error  (frame_error),
        .clear_errors (clear_errors)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] log_q[$];
    bit         exp_ovf = 0, exp_ferr = 0;
    int         exp_fd = 0, dut_fd = 0;
    bit         m_active = 0;
    int         m_bits = 0, m_idx = 0;
    logic [7:0] m_word = '0;
    bit         rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every accepted word must be the next expected word.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            if (frame_done) dut_fd++;
            if (!exp_ovf)  chk("overflow_spurious", overflow, 0);
            if (!exp_ferr) chk("frame_error_spurious", frame_error, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[7:0]);
                    chk("out_last", out_last, e[8]);
                    log_q.push_back({out_last, out_data});
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a completed word enters the FIFO unless it already holds DEPTH.
    task automatic model_word_done();
        logic [8:0] e;
        e = {(m_idx == WPF - 1), m_word};
        if (exp_q.size() >= DEPTH) exp_ovf = 1;
        else begin
            exp_q.push_back(e);
            if (e[8]) exp_fd++;
        end
        m_idx  = (m_idx + 1) % WPF;
        m_bits = 0;
        m_word = '0;
    endtask

    // Bit position in the word for the n-th received bit of that word.
    function automatic int bit_place(input int n);
`ifdef SPI_RX_MSB_FIRST_EN
        return BPW - 1 - n;
`else
        return n;
`endif
    endfunction

    task automatic send_bit(input logic b);
        mosi = b;
        sclk = 1'b1;
        tick(5);
        sclk = 1'b0;
        if (m_active) begin
            m_word = m_word | (8'(b) << bit_place(m_bits));
            m_bits++;
            if (m_bits == BPW) model_word_done();
        end
        tick(5);
    endtask

    // Sends the word in the receiver's bit order so the value arrives intact.
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < BPW; i++) send_bit(w[bit_place(i)]);
    endtask

    task automatic cs_low();
        cs       = 1'b0;
        m_active = 1;
        m_bits   = 0;
        m_idx    = 0;
        m_word   = '0;
        tick(5);
    endtask

    task automatic cs_high();
        if (m_active && (m_bits != 0 || m_idx != 0)) exp_ferr = 1;
        m_active = 0;
        cs       = 1'b1;
        tick(10);
    endtask

    task automatic clear_flags();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        exp_ovf      = 0;
        exp_ferr     = 0;
        tick(2);
        chk("cleared_overflow", overflow, 0);
        chk("cleared_frame_error", frame_error, 0);
    endtask

    task automatic phase_end(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 4000) begin
            tick(1);
            w++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        tick(10);
        chk({name, "_overflow"}, overflow, exp_ovf);
        chk({name, "_frame_error"}, frame_error, exp_ferr);
        chk({name, "_frame_done_count"}, dut_fd, exp_fd);
        chk({name, "_out_valid_idle"}, out_valid, 0);
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_overflow"}, overflow, 0);
        chk({name, "_frame_error"}, frame_error, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_before;
        logic [7:0] exp_single;

        tick(3);
        check_reset_state("reset");
        reset = 1'b1;
        tick(10);

        // One 16-word frame 0x00..0x0F.
        log_q.delete();
        cs_low();
        for (int i = 0; i < 16; i++) send_word(8'(i));
        cs_high();
        phase_end("frame16");
        chk("frame16_count", log_q.size(), 16);
        chk("frame16_first", log_q[0], {1'b0, 8'h00});
        chk("frame16_word14", log_q[14], {1'b0, 8'h0E});
        chk("frame16_last", log_q[15], {1'b1, 8'h0F});
        chk("frame16_fd", dut_fd, 1);

        // Partial second word then cs rise.
        log_q.delete();
        cs_low();
        send_word(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        cs_high();
        phase_end("partial");
        chk("partial_count", log_q.size(), 1);
        chk("partial_word", log_q[0], {1'b0, 8'hA5});
        chk("partial_ferr_set", frame_error, 1);
        clear_flags();

        // Three frames with the consumer stalled: only 32 words fit.
        log_q.delete();
        out_ready = 1'b0;
        fd_before = dut_fd;
        for (int f = 0; f < 3; f++) begin
            cs_low();
            for (int i = 0; i < 16; i++) send_word(8'(f * 16 + i));
            cs_high();
        end
        tick(10);
        chk("ovf_flag_set", overflow, 1);
        chk("ovf_valid_while_stalled", out_valid, 1);
        out_ready = 1'b1;
        phase_end("ovf");
        chk("ovf_count", log_q.size(), 32);
        chk("ovf_first", log_q[0], {1'b0, 8'h00});
        chk("ovf_last", log_q[31], {1'b1, 8'h1F});
        chk("ovf_fd", dut_fd - fd_before, 2);
        clear_flags();

        // 32 words in a single cs-low period.
        log_q.delete();
        fd_before = dut_fd;
        cs_low();
        for (int i = 0; i < 32; i++) send_word(8'((i * 7 + 3) & 8'hFF));
        cs_high();
        phase_end("long");
        chk("long_last15", log_q[15][8], 1);
        chk("long_notlast16", log_q[16][8], 0);
        chk("long_last31", log_q[31][8], 1);
        chk("long_fd", dut_fd - fd_before, 2);

        // Reset mid-word, released with cs still low.
        cs_low();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 0; exp_ferr = 0; exp_fd = 0; dut_fd = 0;
        m_active = 0; m_bits = 0; m_idx = 0; m_word = '0;
        tick(3);
        check_reset_state("midreset");
        reset = 1'b1;
        tick(10);
        send_word(8'h5A);
        tick(20);
        chk("after_reset_no_word", out_valid, 0);
        chk("after_reset_no_ferr", frame_error, 0);
        chk("after_reset_no_ovf", overflow, 0);
        log_q.delete();
        cs_high();
        cs_low();
        send_word(8'h3C);
        cs_high();
        phase_end("rearm");
        chk("rearm_count", log_q.size(), 1);
        chk("rearm_word", log_q[0], {1'b0, 8'h3C});
        clear_flags();

        // Bit order: raw stream 1,0,0,0,0,0,0,0.
`ifdef SPI_RX_MSB_FIRST_EN
        exp_single = 8'h80;
`else
        exp_single = 8'h01;
`endif
        log_q.delete();
        cs_low();
        send_bit(1'b1);
        repeat (7) send_bit(1'b0);
        cs_high();
        phase_end("bitorder");
        chk("bitorder_word", log_q[0], {1'b0, exp_single});
        clear_flags();

        // Random sessions with a randomly stalling consumer.
        rand_ready = 1;
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(1, 20);
            cs_low();
            for (int i = 0; i < n; i++) send_word(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 7)) send_bit(1'($urandom_range(0, 1)));
            cs_high();
        end
        rand_ready = 0;
        tick(2);
        out_ready = 1'b1;
        phase_end("random");
        clear_flags();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
